// File: rtl/led_pkg.sv
// Shared definitions for the LED selection generator: mode encoding,
// default timing parameters and the selection code width.
package led_pkg;

    localparam int SEL_W           = 3;
    localparam int VEC_W           = 5;
    localparam int DB_CYCLES_DEF   = 1_000_000;
    localparam int STEP_CYCLES_DEF = 25_000_000;

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_e;

endpackage

// File: rtl/debounce_vec.sv
// Two-flop synchronizer followed by a vector-wide debouncer: the whole
// vector must hold one value for CYCLES+1 cycles before it is accepted.
module debounce_vec #(
    parameter int WIDTH  = 5,
    parameter int CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] db_o
);

    localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] db_q;
    logic [CNT_W-1:0] cnt_q;

    // Any difference restarts the window; a full window copies the candidate out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                db_q <= cand_q;
            end
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/led_sel_gen.sv
// Selection code generator for a 3-to-8 LED decoder: follows the debounced
// switches in manual mode, or steps up/down periodically in auto mode.
module led_sel_gen
    import led_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sw,
    input  logic             auto_en,
    input  logic             dir,
    output logic [SEL_W-1:0] sel,
    output logic             sel_chg
);

    localparam int STEP_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CYCLES - 1);

    logic [VEC_W-1:0]  db_vec;
    logic [SEL_W-1:0]  sw_db;
    logic              auto_db;
    logic              dir_db;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              sel_chg_q;

    debounce_vec #(
        .WIDTH  (VEC_W),
        .CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw_i ({dir, auto_en, sw}),
        .db_o  (db_vec)
    );

    assign sw_db   = db_vec[SEL_W-1:0];
    assign auto_db = db_vec[SEL_W];
    assign dir_db  = db_vec[SEL_W+1];

    // Leaving AUTO takes priority over a coincident step, so sel holds on the exit edge
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        sel_d   = sel_q;
        case (state_q)
            MANUAL: begin
                sel_d  = sw_db;
                step_d = '0;
                if (auto_db) begin
                    state_d = AUTO;
                end
            end
            AUTO: begin
                if (!auto_db) begin
                    state_d = MANUAL;
                    step_d  = '0;
                end else if (step_q == STEP_MAX) begin
                    step_d = '0;
                    sel_d  = dir_db ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                state_d = MANUAL;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MANUAL;
            step_q    <= '0;
            sel_q     <= '0;
            sel_chg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            sel_q     <= sel_d;
            sel_chg_q <= (sel_d != sel_q);
        end
    end

    assign sel     = sel_q;
    assign sel_chg = sel_chg_q;

endmodule

// File: doc/led_sel_gen.md
LED_SEL_GEN -- requirements
Module: led_sel_gen

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000, SHALL set the debounce stability window in clock cycles (minimum 2).
REQ-002 Parameter STEP_CYCLES, default 25_000_000, SHALL set the auto-step period in clock cycles (minimum 2).
REQ-003 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 sw  input  3  SHALL be the raw, bouncing, clock-asynchronous selection switches.
REQ-006 auto_en  input  1  SHALL be the raw mode switch: 1 selects auto-run, 0 selects manual.
REQ-007 dir  input  1  SHALL be the raw direction switch: 0 counts up, 1 counts down.
REQ-008 sel  output  3  SHALL be the registered selection code fed to the downstream 3-to-8 LED decoder.
REQ-009 sel_chg  output  1  SHALL be a registered one-cycle pulse, high in the cycle after any edge at which sel changed value.

Function
REQ-010 The block SHALL form a 5-bit raw vector {dir, auto_en, sw} and pass it through a two-flop synchronizer.
REQ-011 Debounce: when the synchronized vector differs from the candidate register, the block SHALL load the candidate and clear the stability counter.
REQ-012 Debounce: when the synchronized vector equals the candidate, the counter SHALL increment and saturate at DB_CYCLES-1.
REQ-013 Debounce: at an edge where the counter equals DB_CYCLES-1 and the vector still matches, the block SHALL copy the candidate into the debounced register (sw_db, auto_db, dir_db).
REQ-014 A raw change held stable SHALL reach the debounced register DB_CYCLES+3 edges after it is first sampled, and SHALL reach sel one edge later (DB_CYCLES+4).
REQ-015 A raw pulse or bounce train shorter than DB_CYCLES+1 cycles SHALL leave the debounced register and sel unchanged.
REQ-016 The FSM SHALL have two states, MANUAL and AUTO.
REQ-017 MANUAL: at every edge sel SHALL load sw_db; when auto_db=1 the FSM SHALL go to AUTO at the same edge.
REQ-018 On entry to AUTO, the step counter SHALL clear to 0 and sel SHALL hold its value.
REQ-019 AUTO: the step counter SHALL count 0..STEP_CYCLES-1; at the edge where it equals STEP_CYCLES-1, it SHALL wrap to 0 and sel SHALL step.
REQ-020 The step SHALL be +1 when dir_db=0 and -1 when dir_db=1, modulo 8 (7 -> 0 up; 0 -> 7 down).
REQ-021 A dir_db change in AUTO SHALL affect only the next step and SHALL NOT reset the step counter.
REQ-022 AUTO: when auto_db=0, the FSM SHALL return to MANUAL and sel SHALL load sw_db on the following edge.
REQ-023 sw_db changes SHALL be ignored while in AUTO.
REQ-024 sel_chg SHALL be 0 whenever a MANUAL reload writes an unchanged value.

Reset
REQ-025 While rst=1 (asynchronous assertion), the block SHALL set all registers to 0: synchronizers, candidate, counters, debounced register, sel=0, sel_chg=0, and state=MANUAL.
REQ-026 Reset asserted mid-operation (mid-debounce or mid-AUTO) SHALL discard all progress, with no sel_chg pulse on release.
REQ-027 After rst deasserts, the block SHALL resume normal operation at the first clock edge.

Structure
REQ-028 Shared package led_pkg SHALL hold the state enum type (MANUAL, AUTO), the DB_CYCLES and STEP_CYCLES defaults, and the 3-bit sel width constant.
REQ-029 Synchronizer and debouncer SHALL be one sub-module, debounce_vec (parameters WIDTH, CYCLES), instantiated once with WIDTH=5.
REQ-030 Counter widths SHALL be derived from the parameters with $clog2.

Verification (bench parameters DB_CYCLES=4, STEP_CYCLES=8)
REQ-031 Reset test: assert rst mid-AUTO with sel=5 -> sel=0, sel_chg=0 immediately; MANUAL after release.
REQ-032 Manual latency test: sw 000->011 held -> sel=3 exactly 8 edges later, with one sel_chg pulse the next cycle.
REQ-033 Bounce rejection test: sw toggles 000/101 every 2 cycles for 20 cycles, then settles at 000 -> sel stays 0 with no sel_chg.
REQ-034 Auto-up wrap test: sel=6, set auto_en=1, dir=0 -> sel goes 7, 0, 1 at 8-cycle spacing.
REQ-035 Auto-down wrap test: sel=1, dir=1 in AUTO -> sel goes 0, then 7.
REQ-036 Mode exit test: in AUTO with sw=010, set auto_en=0 -> after debounce, the FSM returns to MANUAL and sel=2 one edge later.
